// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the sequential shift-and-add multiplier.
//   mult_state_t : control FSM state encoding (IDLE, RUN, DONE)
//   cnt_width()  : width of the iteration counter for a given operand width,
//                  wide enough to hold the value word_length itself.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int DEFAULT_WORD_LENGTH = 4;
  localparam int DEFAULT_CNT_WIDTH   = $clog2(DEFAULT_WORD_LENGTH + 1);

  function automatic int cnt_width(input int word_length);
    return $clog2(word_length + 1);
  endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// shift_add_datapath
// Accumulator, shifted multiplicand, multiplier shift register and iteration
// counter for the shift-and-add multiplier, plus the single 2W-bit adder.
// Ports:
//   clk, reset    : clock (rising edge) and asynchronous active-high reset
//   load          : capture operands, clear accumulator, reload counter
//   step          : perform one shift-and-add iteration
//   multiplicand  : operand A (word_length bits, unsigned)
//   multiplier    : operand B (word_length bits, unsigned)
//   acc_next      : accumulator value after the current iteration's add
//   cnt_last      : high when the current iteration is the final one
module shift_add_datapath
  import mult_pkg::*;
#(
  parameter int word_length = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       step,
  input  logic [word_length-1:0]     multiplicand,
  input  logic [word_length-1:0]     multiplier,
  output logic [2*word_length-1:0]   acc_next,
  output logic                       cnt_last
);

  localparam int CNT_W = cnt_width(word_length);

  logic [2*word_length-1:0] acc;
  logic [2*word_length-1:0] mcand;
  logic [word_length-1:0]   mplier;
  logic [CNT_W-1:0]         cnt;

  // The multiplicand is pre-shifted into the 2W-bit field, so the sum of all
  // partial products never exceeds 2W bits and the add cannot overflow.
  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
    cnt_last = (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{word_length{1'b0}}, multiplicand};
      mplier <= multiplier;
      cnt    <= CNT_W'(word_length);
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier
// Unsigned sequential multiplier with a fixed latency of word_length cycles.
// Feeds an enable-gated register downstream: product is its data and done is
// its enable, so exactly one capture happens per finished multiply.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-high reset
//   start        : request a multiply (only honoured in IDLE)
//   multiplicand : operand A, captured on the accepting edge
//   multiplier   : operand B, captured on the accepting edge
//   product      : last completed A*B (2*word_length bits), held between ops
//   done         : one-cycle pulse when product first shows a new result
//   busy         : high while an operation is in progress
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int word_length = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [word_length-1:0]     multiplicand,
  input  logic [word_length-1:0]     multiplier,
  output logic [2*word_length-1:0]   product,
  output logic                       done,
  output logic                       busy
);

  mult_state_t              state;
  logic                     load;
  logic                     step;
  logic [2*word_length-1:0] acc_next;
  logic                     cnt_last;

  // Strobes into the datapath; start is only looked at while idle, so
  // requests during RUN or DONE are dropped here.
  always_comb begin
    load = (state == IDLE) && start;
    step = (state == RUN);
  end

  shift_add_datapath #(
    .word_length (word_length)
  ) u_datapath (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .acc_next     (acc_next),
    .cnt_last     (cnt_last)
  );

  // Product is written from acc_next on the final iteration so that the
  // result appears together with done, without an extra pipeline cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      product <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (cnt_last) begin
            product <= acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
